sprite_table_buffer: RTL
========================

Name: sprite_table_buffer

Overview:
Double-buffered sprite attribute table that feeds the 5632-bit `sprites` input of the sprite compositor.
- The game-logic master (NIOS/PIO bridge) writes 32-bit words into a shadow table at any time.
- A commit request copies the whole shadow table into the active table at the next frame boundary, so the compositor never sees a half-updated frame.
- The block also provides a timed bulk clear and a shadow readback path for software.

Parameters:
- NUM_SPRITES, 16, number of sprite entries
- WORDS_PER_SPRITE, 11, 32-bit words per entry (entry = 352 bits)
- WORD_W, 32, write/read word width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe; accepted only when wr_ready=1
- wr_sprite  in  4  target sprite index
- wr_word  in  4  word index within entry (valid 0..10)
- wr_data  in  32  write data
- wr_ready  out  1  1 when writes are accepted (state != CLEAR)
- wr_err  out  1  sticky; set when an accepted write has wr_word>=11; cleared only by reset
- commit_req  in  1  pulse: request shadow->active copy at next frame_start
- frame_start  in  1  one-cycle pulse from the VGA timing block at start of vertical blank
- commit_pending  out  1  1 while a commit is waiting for frame_start
- commit_done  out  1  one-cycle pulse in the cycle after the copy
- clear_req  in  1  pulse: zero the entire shadow table
- rd_sprite  in  4  readback sprite index
- rd_word  in  4  readback word index
- rd_data  out  32  shadow word, registered, 1-cycle latency; 0 if rd_word>=11
- sprites  out  5632  active table; word w of sprite s at bits [s*352 + w*32 +: 32]

Behaviour:
- Reset (synchronous, high on a clk edge):
  - shadow and active tables = 0; state = IDLE
  - wr_ready=1, wr_err=0, commit_pending=0, commit_done=0, rd_data=0
  - reset mid-CLEAR or mid-PENDING abandons the operation; no commit occurs
- States:
  - IDLE: clear_req -> CLEAR (clr_idx=0); else commit_req -> PENDING. If both assert, clear wins and commit_req is dropped.
  - PENDING: frame_start -> copy shadow->active on that edge; commit_done pulses next cycle; -> IDLE. commit_req is a no-op. clear_req is ignored.
  - CLEAR: each cycle zero shadow entry clr_idx and increment. After the clr_idx=15 cycle -> IDLE; 16 cycles total, wr_ready=0 throughout. commit_req and frame_start are ignored.
- Writes:
  - An accepted write with wr_word<=10 updates the shadow word on the next edge.
  - A write with wr_word>=11 leaves the table unmodified and sets wr_err.
  - wr_en with wr_ready=0 is dropped silently.
- Same-cycle write and copy: active receives the pre-write shadow value. The write lands in shadow only and appears after the next commit.
- Active table changes only on a commit edge and is otherwise stable, including across frame_start pulses with no commit pending.
- commit_pending = (state == PENDING), driven from a register with no combinational path from inputs.
- rd_data reflects shadow contents after any write on the same edge (read-after-write: value visible 1 cycle after the write edge, via rd_data the cycle after that).

Decomposition:
- Package sprite_pkg:
  - NUM_SPRITES, WORDS_PER_SPRITE, WORD_W, ENTRY_W=352, TABLE_W=5632
  - state enum {IDLE, PENDING, CLEAR}
  - function word_lsb(s,w) returning s*ENTRY_W + w*WORD_W
- One natural sub-module: sprite_shadow_ram. Shadow storage with a write port, clear-entry port and registered read port. The top level holds the FSM and the active register.

Test Plan:
- Reset, then write s=2,w=0,data=0xDEADBEEF; no commit, frame_start pulse -> sprites[735:704]=0; rd(2,0) returns 0xDEADBEEF next cycle.
- Same write, then commit_req; 5 cycles later frame_start -> commit_pending=1 until the copy edge; sprites[735:704]=0xDEADBEEF; commit_done pulses once.
- Write s=15,w=10,data=0x12345678 in the same cycle as the commit copy -> sprites[5631:5600] keeps its old value; after a second commit it = 0x12345678.
- clear_req and commit_req together in IDLE -> wr_ready=0 for exactly 16 cycles, commit_pending stays 0; wr_en during CLEAR is dropped; afterwards all rd words read 0.
- Write with wr_word=11 -> wr_err=1 and stays 1; shadow of sprite 0 is unchanged; wr_err survives commit and clear, and clears only on reset.
- Reset asserted while PENDING, then frame_start -> sprites stays all-zero, commit_done never pulses.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and bit-position helper for the sprite table.
package sprite_pkg;

  localparam int NUM_SPRITES      = 16;
  localparam int WORDS_PER_SPRITE = 11;
  localparam int WORD_W           = 32;
  localparam int ENTRY_W          = WORDS_PER_SPRITE * WORD_W;  // 352
  localparam int TABLE_W          = NUM_SPRITES * ENTRY_W;      // 5632
  localparam int IDX_W            = 4;

  // Highest legal word index inside one entry, and highest sprite index.
  localparam logic [IDX_W-1:0] LAST_WORD   = IDX_W'(WORDS_PER_SPRITE - 1);
  localparam logic [IDX_W-1:0] LAST_SPRITE = IDX_W'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  // Bit offset of word w of sprite s inside the flattened table.
  function automatic int word_lsb(input int s, input int w);
    return s * ENTRY_W + w * WORD_W;
  endfunction

endpackage

// File: rtl/sprite_table_buffer_if.sv
// Software-side bus of the sprite table: shadow writes, readback and commit/clear control.
interface sprite_table_buffer_if;
  import sprite_pkg::*;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_sprite;
  logic [IDX_W-1:0]  wr_word;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_err;
  logic              commit_req;
  logic              commit_pending;
  logic              commit_done;
  logic              clear_req;
  logic [IDX_W-1:0]  rd_sprite;
  logic [IDX_W-1:0]  rd_word;
  logic [WORD_W-1:0] rd_data;

  // Game-logic side (NIOS/PIO bridge).
  modport master (
    output wr_en, wr_sprite, wr_word, wr_data,
    output commit_req, clear_req, rd_sprite, rd_word,
    input  wr_ready, wr_err, commit_pending, commit_done, rd_data
  );

  // Table buffer side.
  modport slave (
    input  wr_en, wr_sprite, wr_word, wr_data,
    input  commit_req, clear_req, rd_sprite, rd_word,
    output wr_ready, wr_err, commit_pending, commit_done, rd_data
  );

endinterface

// File: rtl/sprite_shadow_ram.sv
// Shadow sprite table: one write port, one whole-entry clear port, a registered
// word readback port and a flattened view of the full table for the commit copy.
module sprite_shadow_ram
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_sprite,
  input  logic [IDX_W-1:0]   wr_word,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               clr_en,
  input  logic [IDX_W-1:0]   clr_idx,
  input  logic [IDX_W-1:0]   rd_sprite,
  input  logic [IDX_W-1:0]   rd_word,
  output logic [WORD_W-1:0]  rd_data,
  output logic [TABLE_W-1:0] shadow_flat
);

  logic [WORD_W-1:0] mem [NUM_SPRITES][WORDS_PER_SPRITE];
  logic [WORD_W-1:0] rd_data_p1;

  // Storage update: reset zeroes everything, clear zeroes one entry, else a legal write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SPRITES; s++)
        for (int w = 0; w < WORDS_PER_SPRITE; w++)
          mem[IDX_W'(s)][IDX_W'(w)] <= '0;
    end else if (clr_en) begin
      for (int w = 0; w < WORDS_PER_SPRITE; w++)
        mem[clr_idx][IDX_W'(w)] <= '0;
    end else if (wr_en && (wr_word <= LAST_WORD)) begin
      mem[wr_sprite][wr_word] <= wr_data;
    end
  end

  // ---- stage p1: registered readback, zero for out-of-range word indices ----
  always_ff @(posedge clk) begin
    if (reset)
      rd_data_p1 <= '0;
    else if (rd_word <= LAST_WORD)
      rd_data_p1 <= mem[rd_sprite][rd_word];
    else
      rd_data_p1 <= '0;
  end

  assign rd_data = rd_data_p1;

  // Flatten the storage into the compositor bit layout for the commit copy.
  always_comb begin
    shadow_flat = '0;
    for (int s = 0; s < NUM_SPRITES; s++)
      for (int w = 0; w < WORDS_PER_SPRITE; w++)
        shadow_flat[word_lsb(s, w) +: WORD_W] = mem[IDX_W'(s)][IDX_W'(w)];
  end

endmodule

// File: rtl/sprite_table_buffer.sv
// Double-buffered sprite attribute table. Software edits the shadow copy at any
// time; a commit copies it to the active table on the next frame_start so the
// compositor never sees a partially updated frame.
module sprite_table_buffer
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sprite_table_buffer_if.slave bus,
  input  logic                 frame_start,
  output logic [TABLE_W-1:0]   sprites
);

  state_t             state;
  logic [IDX_W-1:0]   clr_idx;
  logic               wr_accept;
  logic               copy_en;
  logic               clr_en;
  logic               wr_err_r;
  logic               commit_done_r;
  logic [TABLE_W-1:0] shadow_flat;
  logic [TABLE_W-1:0] active;

  assign wr_accept = bus.wr_en && (state != CLEAR);
  assign copy_en   = (state == PENDING) && frame_start;
  assign clr_en    = (state == CLEAR);

  // Control FSM: clear beats commit in IDLE; PENDING waits for the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (bus.commit_req) begin
            state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_start)
            state <= IDLE;
        end
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_SPRITE)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error for accepted writes that name a word past the end of an entry.
  always_ff @(posedge clk) begin
    if (reset)
      wr_err_r <= 1'b0;
    else if (wr_accept && (bus.wr_word > LAST_WORD))
      wr_err_r <= 1'b1;
  end

  // One-cycle completion pulse following the copy edge.
  always_ff @(posedge clk) begin
    if (reset)
      commit_done_r <= 1'b0;
    else
      commit_done_r <= copy_en;
  end

  // Active table: loads the pre-edge shadow contents only on the commit edge.
  always_ff @(posedge clk) begin
    if (reset)
      active <= '0;
    else if (copy_en)
      active <= shadow_flat;
  end

  sprite_shadow_ram u_shadow (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_accept),
    .wr_sprite   (bus.wr_sprite),
    .wr_word     (bus.wr_word),
    .wr_data     (bus.wr_data),
    .clr_en      (clr_en),
    .clr_idx     (clr_idx),
    .rd_sprite   (bus.rd_sprite),
    .rd_word     (bus.rd_word),
    .rd_data     (bus.rd_data),
    .shadow_flat (shadow_flat)
  );

  assign bus.wr_ready       = (state != CLEAR);
  assign bus.commit_pending = (state == PENDING);
  assign bus.wr_err         = wr_err_r;
  assign bus.commit_done    = commit_done_r;
  assign sprites            = active;

endmodule
